ora_misr: RTL and testbench

- Output response analyzer for the BIST loop; the receive end of the test pattern generator path.
- Compacts the circuit-under-test response, one word per enabled cycle, into a multiple-input signature register (MISR).
- After a fixed pattern count, compares the signature with a golden value and reports done/pass to the BIST controller.

---
 rtl/bist_pkg.sv | 15 +
 rtl/ora_misr_if.sv | 15 +
 rtl/misr_reg.sv | 54 +++++
 rtl/ora_misr.sv | 133 +++++++++++++
 tb/tb_ora_misr.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/bist_pkg.sv
// Shared BIST constants and the response-analyzer state encoding.
// The pattern generator imports the same width constant.
package bist_pkg;

    localparam int             BIST_WIDTH = 4;
    localparam logic [3:0]     MISR_POLY  = 4'b0011;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPACT = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } bist_state_e;

endpackage

// File: rtl/ora_misr_if.sv
// Controller <-> output response analyzer bus.
// The master side is the BIST controller; the slave side is ora_misr.
interface ora_misr_if #(
  parameter int WIDTH = 4
) ();
  logic             en;
  logic [WIDTH-1:0] R;
  logic [WIDTH-1:0] sig;
  logic             busy;
  logic             done;
  logic             pass;

  modport master (output en, R, input sig, busy, done, pass);
  modport slave  (input en, R, output sig, busy, done, pass);
endinterface

// File: rtl/misr_reg.sv
// Galois MISR register: async reset to SEED, synchronous SEED load, enabled step.
// Load and step together compact R into SEED rather than into the held value.
module misr_reg
  import bist_pkg::*;
#(
  parameter int               WIDTH = BIST_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = MISR_POLY,
  parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] r_i,
  output logic [WIDTH-1:0] sig_o
);

  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;
  logic [WIDTH-1:0] base_s;

  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s,
                                                 input logic [WIDTH-1:0] r);
    return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY : {WIDTH{1'b0}}) ^ r;
  endfunction

  // Next-state selection for the signature.
  always_comb begin
    base_s = sig_q;
    sig_d  = sig_q;
    if (load_i) begin
      base_s = SEED;
    end else begin
      base_s = sig_q;
    end
    if (step_i) begin
      sig_d = misr_step(base_s, r_i);
    end else begin
      sig_d = base_s;
    end
  end

  // Signature register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/ora_misr.sv
// Output response analyzer: compacts NUM_PATTERNS response words into a MISR,
// then compares the signature with GOLDEN and reports done/pass.
module ora_misr
  import bist_pkg::*;
#(
  parameter int               WIDTH        = BIST_WIDTH,
  parameter logic [WIDTH-1:0] POLY         = MISR_POLY,
  parameter logic [WIDTH-1:0] SEED         = {WIDTH{1'b0}},
  parameter int               NUM_PATTERNS = 15,
  parameter logic [WIDTH-1:0] GOLDEN       = {WIDTH{1'b0}}
) (
  input  logic       clk,
  input  logic       rst,
  ora_misr_if.slave  bus
);

  localparam int CW = $clog2(NUM_PATTERNS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_PATTERNS);

  bist_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc_s;
  logic          busy_q;
  logic          done_q;
  logic          pass_q;
  logic          load_s;
  logic          step_s;
  logic [WIDTH-1:0] sig_s;

  assign cnt_inc_s = cnt_q + CW'(1);

  // MISR control: IDLE reloads SEED (and compacts the first word from it),
  // COMPACT steps only on enabled cycles, other states hold.
  always_comb begin
    load_s = 1'b0;
    step_s = 1'b0;
    case (state_q)
      IDLE: begin
        load_s = 1'b1;
        step_s = bus.en;
      end
      COMPACT: begin
        load_s = 1'b0;
        step_s = bus.en;
      end
      default: begin
        load_s = 1'b0;
        step_s = 1'b0;
      end
    endcase
  end

  misr_reg #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk    (clk),
    .rst    (rst),
    .load_i (load_s),
    .step_i (step_s),
    .r_i    (bus.R),
    .sig_o  (sig_s)
  );

  // Session FSM with counter and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          pass_q <= 1'b0;
          if (bus.en) begin
            cnt_q   <= CW'(1);
            busy_q  <= 1'b1;
            state_q <= (NUM_PATTERNS == 1) ? COMPARE : COMPACT;
          end else begin
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        COMPACT: begin
          // A dropped en on the final count pauses without sampling the word.
          if (bus.en) begin
            cnt_q <= cnt_inc_s;
            if (cnt_inc_s == LAST_CNT) begin
              state_q <= COMPARE;
            end else begin
              state_q <= COMPACT;
            end
          end else begin
            state_q <= COMPACT;
          end
        end
        COMPARE: begin
          pass_q  <= (sig_s == GOLDEN);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= DONE;
        end
        DONE: begin
          if (!bus.en) begin
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= {CW{1'b0}};
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sig  = sig_s;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.pass = pass_q;

endmodule

// File: tb/tb_ora_misr.sv
// Directed bench for ora_misr with NUM_PATTERNS=3, SEED=0, GOLDEN=3.
// Expected signatures come from a bench-side MISR model through a scoreboard queue.
module tb_ora_misr;
  import bist_pkg::*;

  localparam int         W      = 4;
  localparam int         NP     = 3;
  localparam logic [3:0] T_SEED = 4'h0;
  localparam logic [3:0] T_GOLD = 4'h3;
  localparam logic [3:0] T_POLY = 4'b0011;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ora_misr_if #(.WIDTH(W)) bus ();

  ora_misr #(
    .WIDTH        (W),
    .POLY         (T_POLY),
    .SEED         (T_SEED),
    .NUM_PATTERNS (NP),
    .GOLDEN       (T_GOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] sig_sb[$];
  logic         pass_sb[$];
  logic [W-1:0] model_sig;

  function automatic logic [W-1:0] model_step(input logic [W-1:0] s, input logic [W-1:0] r);
    logic [W-1:0] sh;
    sh = s << 1;
    if (s[W-1]) sh = sh ^ T_POLY;
    return sh ^ r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [W-1:0] r);
    bus.en = 1'b1;
    bus.R  = r;
    model_sig = model_step(model_sig, r);
    sig_sb.push_back(model_sig);
    tick();
    check("word_sig",  bus.sig, sig_sb.pop_front());
    check("word_busy", W'(bus.busy), W'(1));
    check("word_done", W'(bus.done), W'(0));
  endtask

  task automatic end_session();
    pass_sb.push_back(model_sig == T_GOLD);
    tick();
    check("cmp_done", W'(bus.done), W'(1));
    check("cmp_busy", W'(bus.busy), W'(0));
    check("cmp_pass", W'(bus.pass), W'(pass_sb.pop_front()));
    check("cmp_sig",  bus.sig, model_sig);
  endtask

  task automatic exit_session();
    bus.en = 1'b0;
    tick();
    check("exit_done", W'(bus.done), W'(0));
    check("exit_pass", W'(bus.pass), W'(0));
    check("exit_sig_hold", bus.sig, model_sig);
    tick();
    check("exit_sig_seed", bus.sig, T_SEED);
    model_sig = T_SEED;
  endtask

  initial begin
    bus.en = 1'b0;
    bus.R  = 4'h0;
    model_sig = T_SEED;

    tick();
    tick();
    check("rst_sig",  bus.sig, T_SEED);
    check("rst_busy", W'(bus.busy), W'(0));
    check("rst_done", W'(bus.done), W'(0));
    check("rst_pass", W'(bus.pass), W'(0));
    rst = 1'b1;

    // Reset asserted mid-session after two of three words.
    drive_word(4'h1);
    drive_word(4'h2);
    rst = 1'b0;
    #1;
    check("abort_sig",  bus.sig, 4'h0);
    check("abort_busy", W'(bus.busy), W'(0));
    check("abort_done", W'(bus.done), W'(0));
    check("abort_pass", W'(bus.pass), W'(0));
    model_sig = T_SEED;
    bus.en = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_busy", W'(bus.busy), W'(0));
      check("idle_done", W'(bus.done), W'(0));
      check("idle_sig",  bus.sig, T_SEED);
    end

    // Known signature, then hold in DONE for 5 cycles and exit.
    drive_word(4'h1);
    drive_word(4'h2);
    drive_word(4'h3);
    check("known_final", bus.sig, 4'h3);
    end_session();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_done", W'(bus.done), W'(1));
      check("hold_pass", W'(bus.pass), W'(1));
      check("hold_sig",  bus.sig, 4'h3);
    end
    exit_session();

    // Back-to-back faulty session.
    drive_word(4'hF);
    drive_word(4'hF);
    drive_word(4'hF);
    check("fault_final", bus.sig, 4'hB);
    end_session();
    check("fault_pass", W'(bus.pass), W'(0));
    exit_session();

    // Pause of two cycles after the first word.
    drive_word(4'h1);
    bus.en = 1'b0;
    bus.R  = 4'h7;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("pause_sig",  bus.sig, 4'h1);
      check("pause_busy", W'(bus.busy), W'(1));
      check("pause_done", W'(bus.done), W'(0));
    end
    drive_word(4'h2);
    drive_word(4'h3);
    end_session();
    check("pause_final", bus.sig, 4'h3);
    check("pause_pass",  W'(bus.pass), W'(1));
    exit_session();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
